nibble_deser: RTL
=================

Name: nibble_deser

Overview:
- Serial-to-parallel front end that assembles framed bit streams into WIDTH-bit words.
- Presents each word on a valid/ready output to the downstream hold register.
- Sits directly upstream of the 4-bit clearable data register. dout feeds that register's d input; the register's loading logic drives dout_ready.
- Double-buffered (shift register + output register), so a new frame can be shifted while the previous word waits to be consumed.

Parameters:
- WIDTH, 4, data bits per frame and output word width.
- MSB_FIRST, 1, 1 = first serial bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

Ports:
- clk  input  1  clock, all state on rising edge
- clrb  input  1  asynchronous active-low reset
- sin_valid  input  1  sin_bit is valid this cycle
- sin_bit  input  1  serial data bit
- sin_start  input  1  qualified by sin_valid; marks the first bit of a frame
- dout  output  WIDTH  assembled word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  downstream accepts dout this cycle
- busy  output  1  frame in progress (state SHIFT or WAIT)
- overrun  output  1  sticky: a valid bit was dropped
- ovr_clr  input  1  synchronous clear of overrun and perr
- perr  output  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (clrb=0, async): state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, overrun=0, perr=0. Reset mid-frame discards the partial frame and any held word.
- Only cycles with sin_valid=1 advance the frame. Gaps of any length are legal.
- IDLE:
  - sin_valid and sin_start -> capture the bit, count=1, go to SHIFT.
  - sin_valid without sin_start -> bit ignored, no flag.
- SHIFT:
  - Each valid bit shifts in, direction per MSB_FIRST, and count increments.
  - sin_start with sin_valid -> resync: partial frame discarded, this bit becomes bit 1, count=1.
  - On the last bit (count reaches WIDTH):
    - If the output reg is free, or dout_valid and dout_ready are both high this cycle: the completed word loads into dout at that same edge, dout_valid=1, go to IDLE.
    - Otherwise go to WAIT holding the completed word.
- WAIT:
  - When dout_valid and dout_ready are both high: the held word moves to dout at that edge, dout_valid stays 1, go to IDLE.
  - Any sin_valid bit arriving in WAIT is dropped and sets overrun, including a sin_start bit.
- Output handshake:
  - Transfer occurs when dout_valid and dout_ready are both high.
  - dout is stable while dout_valid=1 and no transfer occurs.
  - After a transfer with no new word, dout_valid=0 and dout retains its last value.
- Latency: dout_valid rises the cycle after the edge that samples the last bit, given a free output reg.
- Throughput: back-to-back frames with no gaps are sustained while dout_ready=1.
- busy = (state != IDLE).
- overrun and perr:
  - Sticky until ovr_clr=1 or reset.
  - ovr_clr and a set event in the same cycle -> set wins.
- dout_ready while dout_valid=0 has no effect.

Optional Feature:
- Macro: NIBBLE_DESER_PARITY_EN.
- Defined:
  - A frame is WIDTH data bits followed by one even-parity bit.
  - Completion occurs on the parity bit.
  - Parity mismatch -> word discarded (no dout_valid), perr set, go to IDLE.
  - Latency is one valid bit longer.
- Undefined:
  - Frame is WIDTH bits only.
  - perr is tied to 0 and ovr_clr affects only overrun.

Decomposition:
- Shared package: state encoding constants IDLE=2'd0, SHIFT=2'd1, WAIT=2'd2, and the default WIDTH constant.
- The bit counter width is derived from WIDTH (+1 with parity).
- One natural sub-module: nibble_deser_outbuf, the output holding register with valid/ready logic.

Test Plan:
- Reset, then frame sin_start with bits 1,0,1,1, dout_ready=1, MSB_FIRST=1 -> dout=4'b1011 and dout_valid high for 1 cycle, the cycle after the 4th bit.
- Same frame with sin_valid gaps of 3 cycles between bits -> same dout=4'b1011, busy high throughout the frame.
- dout_ready=0, send frames 4'b0001 then 4'b0010, then 2 more bits -> dout=0001 held, state WAIT, dropped bits set overrun=1. Raise dout_ready -> dout=0010 next. ovr_clr -> overrun=0.
- sin_start asserted again after 2 bits of a frame, then 1,1,0,0 -> dout=4'b1100, partial bits discarded.
- Pull clrb low mid-frame with dout_valid=1 -> dout=0, dout_valid=0, busy=0 immediately (async), without waiting for a clock edge.
- With NIBBLE_DESER_PARITY_EN: frame 0,0,1,1 + parity 0 -> dout=4'b0011. Frame 0,1,1,1 + parity 0 -> no dout_valid, perr=1.

Source files
------------

// File: rtl/nibble_deser_pkg.sv
// rtl/nibble_deser_pkg.sv - shared state encoding and sizing constants for nibble_deser
package nibble_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

`ifdef NIBBLE_DESER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/nibble_deser_outbuf.sv
// rtl/nibble_deser_outbuf.sv - output holding register with valid/ready handshake
module nibble_deser_outbuf
  import nibble_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_free,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             i_tready
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Free when empty or being drained this cycle, so a load can replace the word in flight.
  assign o_free   = !r_valid || i_tready;
  assign o_tdata  = r_data;
  assign o_tvalid = r_valid;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_tready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_deser.sv
// rtl/nibble_deser.sv - framed serial-to-parallel deserializer with double-buffered output
// Optional trailing even-parity bit per frame when NIBBLE_DESER_PARITY_EN is defined.
module nibble_deser
  import nibble_deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             perr
);

  localparam int FRAME_LEN = WIDTH + PARITY_BITS;
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [WIDTH-1:0] w_base, w_shift_in, w_word, w_load_word;
  logic             w_ok, w_load, w_free, w_ovr_set;
  logic             r_overrun;

  // A start bit always begins from an empty shifter, which also covers resync.
  always_comb begin
    w_base     = sin_start ? '0 : r_shift;
    w_shift_in = MSB_FIRST ? {w_base[WIDTH-2:0], sin_bit} : {sin_bit, w_base[WIDTH-1:1]};
  end

`ifdef NIBBLE_DESER_PARITY_EN
  // The final bit is parity only; data already sits complete in the shifter.
  assign w_word = r_shift;
  assign w_ok   = ~(^{r_shift, sin_bit});
`else
  assign w_word = w_shift_in;
  assign w_ok   = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_load_word = r_shift;
    w_ovr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sin_valid && sin_start) begin
          w_shift_nxt = w_shift_in;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          if (sin_start) begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = CW'(1);
          end else if (r_cnt == LAST_CNT) begin
            w_shift_nxt = w_word;
            w_load_word = w_word;
            w_cnt_nxt   = '0;
            if (!w_ok) begin
              w_state_nxt = IDLE;
            end else if (w_free) begin
              w_load      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = WAIT;
            end
          end else begin
            w_shift_nxt = w_shift_in;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
      end
      WAIT: begin
        w_ovr_set = sin_valid;
        if (dout_valid && dout_ready) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef NIBBLE_DESER_PARITY_EN
  logic r_perr;
  logic w_perr_set;

  assign w_perr_set = (r_state == SHIFT) && sin_valid && !sin_start &&
                      (r_cnt == LAST_CNT) && !w_ok;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      r_perr <= 1'b0;
    end else if (w_perr_set) begin
      r_perr <= 1'b1;
    end else if (ovr_clr) begin
      r_perr <= 1'b0;
    end
  end

  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif

  assign busy    = (r_state != IDLE);
  assign overrun = r_overrun;

  nibble_deser_outbuf #(
    .WIDTH (WIDTH)
  ) u_outbuf (
    .clk      (clk),
    .clrb     (clrb),
    .i_load   (w_load),
    .i_word   (w_load_word),
    .o_free   (w_free),
    .o_tdata  (dout),
    .o_tvalid (dout_valid),
    .i_tready (dout_ready)
  );

endmodule
